// File: rtl/hpdmc_rdcapture_if.sv
// ---------------------------------------------------------------------------
// hpdmc_rdcapture_if
//   Bundles the request and data signals between the hpdmc read controller,
//   the IDDR capture array and the read-path consumer.
//   The slave side is the capture block. The master side is the controller
//   and consumer, which is also the testbench.
//
//   rd_issue    READ command issued this cycle (controller -> capture)
//   rd_lat      read latency in cycles, quasi-static (controller -> capture)
//   q0 / q1     rising / falling edge beat of this cycle (IDDR -> capture)
//   dout        {q1,q0} word at the FIFO head (capture -> consumer)
//   dout_last   head word closes its burst
//   dout_valid  head word valid
//   dout_ready  consumer takes the head this cycle (consumer -> capture)
//   issue_err   pulse: a READ was refused because it came too early
//   overflow    sticky: a captured word was dropped because the FIFO was full
//   busy        a read is in flight or words are still queued
// ---------------------------------------------------------------------------
interface hpdmc_rdcapture_if #(
    parameter int DQ_WIDTH = 16,
    parameter int LAT_MAX  = 15
);
    localparam int LAT_W = $clog2(LAT_MAX + 1);

    logic                    rd_issue;
    logic [LAT_W-1:0]        rd_lat;
    logic [DQ_WIDTH-1:0]     q0;
    logic [DQ_WIDTH-1:0]     q1;
    logic [2*DQ_WIDTH-1:0]   dout;
    logic                    dout_last;
    logic                    dout_valid;
    logic                    dout_ready;
    logic                    issue_err;
    logic                    overflow;
    logic                    busy;

    modport master (
        output rd_issue, rd_lat, q0, q1, dout_ready,
        input  dout, dout_last, dout_valid, issue_err, overflow, busy
    );

    modport slave (
        input  rd_issue, rd_lat, q0, q1, dout_ready,
        output dout, dout_last, dout_valid, issue_err, overflow, busy
    );
endinterface

// File: rtl/hpdmc_rdcapture.sv
// ---------------------------------------------------------------------------
// hpdmc_rdcapture
//   DDR read capture for hpdmc. The block receives q0/q1 beats that the IDDR
//   array has already moved into the sys_clk domain.
//   A delay line counts rd_lat cycles from each accepted READ and then starts
//   a capture of BC = BURST_LEN/2 words. Each word is {q1,q0}, and the last
//   word of every burst is tagged. The words go into a small FIFO with a
//   valid/ready head.
//
//   Ports:
//     sys_clk    system clock, all state on the rising edge
//     sys_rst_n  asynchronous active-low reset
//     bus        hpdmc_rdcapture_if.slave. This carries the issue and latency
//                inputs, the q0/q1 beats, the FIFO head with its valid/ready
//                handshake, and the issue_err / overflow / busy status.
//
//   Timing, with T the edge where the READ is accepted and L the effective
//   rd_lat:
//     - capture edges are T+L .. T+L+BC-1
//     - a word captured at edge E is pushed at edge E+1
//     - that word is visible on dout after edge E+1
// ---------------------------------------------------------------------------
module hpdmc_rdcapture #(
    parameter int DQ_WIDTH   = 16,
    parameter int BURST_LEN  = 4,
    parameter int LAT_MAX    = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    hpdmc_rdcapture_if.slave   bus
);

    localparam int BC     = BURST_LEN / 2;
    localparam int BEAT_W = (BC > 1) ? $clog2(BC) : 1;
    localparam int LAT_W  = $clog2(LAT_MAX + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = 2 * DQ_WIDTH;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BC - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_CAPTURE
    } state_t;

    // Latency 0 is meaningless for a registered capture, so it is treated as 1.
    // Values beyond the delay line length are clamped to its last tap.
    function automatic logic [LAT_W-1:0] sat_lat(input logic [LAT_W-1:0] lat);
        if (lat == '0)
            return LAT_W'(1);
        else if (int'(lat) > LAT_MAX)
            return LAT_W'(LAT_MAX);
        else
            return lat;
    endfunction

    // ---------------------------------------------------------------
    // Issue guard and latency delay line
    // ---------------------------------------------------------------
    logic [LAT_W-1:0]   lat_eff;
    logic [LAT_W-1:0]   tap_idx;
    logic               issue_ok;
    logic               start;

    logic [BEAT_W-1:0]  cool_q, cool_d;
    logic [LAT_MAX-1:0] dl_q, dl_d;
    logic               rej_q;
    logic               issue_err_q;

    assign lat_eff  = sat_lat(bus.rd_lat);
    assign tap_idx  = lat_eff - 1'b1;
    assign issue_ok = bus.rd_issue & (cool_q == '0);
    assign start    = dl_q[tap_idx];

    always_comb begin
        cool_d = cool_q;
        if (issue_ok)
            cool_d = BEAT_LAST;
        else if (cool_q != '0)
            cool_d = cool_q - 1'b1;
    end

    // Bits past the active tap are held at zero. An issue then leaves the
    // line as soon as it has produced its start, so busy drops right after
    // the burst instead of waiting for the full line length.
    always_comb begin
        dl_d    = '0;
        dl_d[0] = issue_ok;
        for (int i = 1; i < LAT_MAX; i++) begin
            if (i < int'(lat_eff))
                dl_d[i] = dl_q[i-1];
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cool_q      <= '0;
            dl_q        <= '0;
            rej_q       <= 1'b0;
            issue_err_q <= 1'b0;
        end else begin
            cool_q      <= cool_d;
            dl_q        <= dl_d;
            // The refusal is registered first, and the pulse appears on the
            // port one cycle after that.
            rej_q       <= bus.rd_issue & ~issue_ok;
            issue_err_q <= rej_q;
        end
    end

    // ---------------------------------------------------------------
    // Burst framing FSM and capture register
    // ---------------------------------------------------------------
    state_t             state_q;
    logic [BEAT_W-1:0]  beat_q;
    logic [BEAT_W-1:0]  beat_idx;
    logic               cap_en;
    logic               cap_last;

    logic               cap_vld_q;
    logic               cap_last_q;
    logic [WORD_W-1:0]  cap_data_q;

    // beat_idx is the position, within its burst, of the word captured at
    // this edge.
    assign cap_en   = start | (state_q == S_CAPTURE);
    assign beat_idx = (state_q == S_CAPTURE) ? beat_q + 1'b1 : '0;
    assign cap_last = (beat_idx == BEAT_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            cap_vld_q  <= 1'b0;
            cap_last_q <= 1'b0;
        end else begin
            cap_vld_q  <= cap_en;
            cap_last_q <= cap_en & cap_last;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        beat_q  <= '0;
                        // A one-word burst is complete on its start edge.
                        state_q <= (BC == 1) ? S_IDLE : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (cap_last) begin
                        beat_q  <= '0;
                        state_q <= start ? S_CAPTURE : S_IDLE;
                    end else begin
                        beat_q  <= beat_idx;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    beat_q  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (cap_en)
            cap_data_q <= {bus.q1, bus.q0};
    end

    // ---------------------------------------------------------------
    // Output FIFO
    // ---------------------------------------------------------------
    logic [WORD_W:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [PTR_W-1:0]   head_sel;

    logic               push;
    logic               pop;
    logic               full;
    logic               push_ok;

    assign push    = cap_vld_q;
    assign pop     = (count_q != '0) & bus.dout_ready;
    assign full    = (count_q == CNT_FULL);
    // When the FIFO is full, a pop on the same edge frees the slot the push
    // needs.
    assign push_ok = push & (~full | pop);

    always_comb begin
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
        overflow_d = overflow_q | (push & full & ~pop);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= {cap_last_q, cap_data_q};
        end
    end

    // When the FIFO is empty, write and read pointers are equal. The slot
    // just behind the read pointer holds the most recently popped word, and
    // it stays intact until the FIFO fills again. Showing that slot keeps
    // dout at its last value while dout_valid is low.
    assign head_sel = (count_q != '0) ? rd_ptr_q : rd_ptr_q - 1'b1;

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign {bus.dout_last, bus.dout} = mem_q[head_sel];
    assign bus.dout_valid = (count_q != '0);
    assign bus.issue_err  = issue_err_q;
    assign bus.overflow   = overflow_q;
    assign bus.busy       = (|dl_q) | (state_q == S_CAPTURE) | cap_vld_q
                          | (count_q != '0);

endmodule

// File: tb/tb_hpdmc_rdcapture.sv
module tb_hpdmc_rdcapture;

    logic sys_clk;
    logic sys_rst_n;

    hpdmc_rdcapture_if #(.DQ_WIDTH(16), .LAT_MAX(15)) bus ();

    hpdmc_rdcapture #(
        .DQ_WIDTH   (16),
        .BURST_LEN  (4),
        .LAT_MAX    (15),
        .FIFO_DEPTH (4)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          cnum  = 0;
    logic        err_seen;
    logic [32:0] popq [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive the inputs, log a pop if one will happen at this edge,
    // clock, then settle 1 time unit past the edge.
    task automatic cyc_q(input logic iss, input logic rdy, input logic [15:0] a, input logic [15:0] b);
        bus.rd_issue   = iss;
        bus.dout_ready = rdy;
        bus.q0         = a;
        bus.q1         = b;
        #0;
        if (bus.dout_valid && bus.dout_ready)
            popq.push_back({bus.dout_last, bus.dout});
        @(posedge sys_clk);
        #1;
        err_seen = err_seen | bus.issue_err;
        cnum++;
    endtask

    // The beat pattern for cycle c is q0 = 1000+c and q1 = 2000+c.
    task automatic cyc(input logic iss, input logic rdy);
        cyc_q(iss, rdy, 16'(16'h1000 + cnum), 16'(16'h2000 + cnum));
    endtask

    task automatic start_scen();
        cnum     = 0;
        err_seen = 1'b0;
        popq.delete();
    endtask

    task automatic do_reset();
        bus.rd_issue   = 1'b0;
        bus.dout_ready = 1'b0;
        sys_rst_n      = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    task automatic scen1(input string p);
        start_scen();
        cyc_q(1'b1, 1'b1, 16'h0, 16'h0);
        cyc_q(1'b0, 1'b1, 16'h0, 16'h0);
        cyc_q(1'b0, 1'b1, 16'h0, 16'h0);
        cyc_q(1'b0, 1'b1, 16'h1111, 16'h2222);
        chk({p, " c3 valid"}, 64'(bus.dout_valid), 64'd0);
        chk({p, " c3 busy"},  64'(bus.busy),       64'd1);
        cyc_q(1'b0, 1'b1, 16'h3333, 16'h4444);
        chk({p, " c4 valid"}, 64'(bus.dout_valid), 64'd1);
        chk({p, " c4 dout"},  64'(bus.dout),       64'h22221111);
        chk({p, " c4 last"},  64'(bus.dout_last),  64'd0);
        cyc_q(1'b0, 1'b1, 16'h0, 16'h0);
        chk({p, " c5 valid"}, 64'(bus.dout_valid), 64'd1);
        chk({p, " c5 dout"},  64'(bus.dout),       64'h44443333);
        chk({p, " c5 last"},  64'(bus.dout_last),  64'd1);
        cyc_q(1'b0, 1'b1, 16'h0, 16'h0);
        chk({p, " c6 valid"}, 64'(bus.dout_valid), 64'd0);
        chk({p, " c6 busy"},  64'(bus.busy),       64'd0);
        chk({p, " c6 hold"},  64'(bus.dout),       64'h44443333);
        chk({p, " issue_err"}, 64'(err_seen),      64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst_n      = 1'b0;
        bus.rd_issue   = 1'b0;
        bus.rd_lat     = 4'd3;
        bus.q0         = '0;
        bus.q1         = '0;
        bus.dout_ready = 1'b0;
        err_seen       = 1'b0;
        do_reset();

        chk("rst dout",      64'(bus.dout),       64'd0);
        chk("rst dout_last", 64'(bus.dout_last),  64'd0);
        chk("rst valid",     64'(bus.dout_valid), 64'd0);
        chk("rst issue_err", 64'(bus.issue_err),  64'd0);
        chk("rst overflow",  64'(bus.overflow),   64'd0);
        chk("rst busy",      64'(bus.busy),       64'd0);

        // Single burst with rd_lat=3
        scen1("s1");

        // Back-to-back bursts two cycles apart
        start_scen();
        cyc(1'b1, 1'b1); cyc(1'b0, 1'b1); cyc(1'b1, 1'b1); cyc(1'b0, 1'b1);
        chk("s2 c3 valid", 64'(bus.dout_valid), 64'd0);
        cyc(1'b0, 1'b1);
        chk("s2 c4 dout", {31'd0, bus.dout_last, bus.dout}, {31'd0, 1'b0, 32'h20031003});
        chk("s2 c4 valid", 64'(bus.dout_valid), 64'd1);
        cyc(1'b0, 1'b1);
        chk("s2 c5 dout", {31'd0, bus.dout_last, bus.dout}, {31'd0, 1'b1, 32'h20041004});
        cyc(1'b0, 1'b1);
        chk("s2 c6 dout", {31'd0, bus.dout_last, bus.dout}, {31'd0, 1'b0, 32'h20051005});
        chk("s2 c6 valid", 64'(bus.dout_valid), 64'd1);
        cyc(1'b0, 1'b1);
        chk("s2 c7 dout", {31'd0, bus.dout_last, bus.dout}, {31'd0, 1'b1, 32'h20061006});
        chk("s2 c7 valid", 64'(bus.dout_valid), 64'd1);
        cyc(1'b0, 1'b1);
        chk("s2 c8 valid", 64'(bus.dout_valid), 64'd0);
        chk("s2 words",    64'(popq.size()),    64'd4);
        chk("s2 issue_err", 64'(err_seen),      64'd0);

        // Second issue one cycle after the first is refused
        start_scen();
        cyc(1'b1, 1'b1); cyc(1'b1, 1'b1);
        chk("s3 c1 issue_err", 64'(bus.issue_err), 64'd0);
        cyc(1'b0, 1'b1);
        chk("s3 c2 issue_err", 64'(bus.issue_err), 64'd1);
        cyc(1'b0, 1'b1);
        chk("s3 c3 issue_err", 64'(bus.issue_err), 64'd0);
        repeat (4) cyc(1'b0, 1'b1);
        chk("s3 words", 64'(popq.size()), 64'd2);
        chk("s3 word2", 64'(popq[1]),     {31'd0, 1'b1, 32'h20041004});
        chk("s3 busy",  64'(bus.busy),    64'd0);

        // Full FIFO with a pop on the push edge: the push is accepted
        do_reset();
        start_scen();
        cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
        chk("s5 c7 dout",     64'(bus.dout),     64'h20031003);
        chk("s5 c7 overflow", 64'(bus.overflow), 64'd0);
        cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
        chk("s5 c11 dout", 64'(bus.dout), 64'h20051005);
        cyc(1'b0, 1'b0);
        chk("s5 c12 overflow", 64'(bus.overflow), 64'd0);
        repeat (4) cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        chk("s5 valid", 64'(bus.dout_valid), 64'd0);
        chk("s5 words", 64'(popq.size()),    64'd6);
        chk("s5 word5", 64'(popq[4]),        {31'd0, 1'b0, 32'h20091009});
        chk("s5 word6", 64'(popq[5]),        {31'd0, 1'b1, 32'h200a100a});
        chk("s5 overflow", 64'(bus.overflow), 64'd0);

        // Three bursts into a stalled FIFO: two words are dropped
        start_scen();
        cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
        chk("s4 c5 dout", 64'(bus.dout), 64'h20031003);
        cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
        chk("s4 c7 overflow", 64'(bus.overflow), 64'd0);
        cyc(1'b0, 1'b0);
        chk("s4 c8 overflow", 64'(bus.overflow), 64'd1);
        cyc(1'b0, 1'b0);
        chk("s4 c9 hold", {31'd0, bus.dout_last, bus.dout}, {31'd0, 1'b0, 32'h20031003});
        repeat (4) cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("s4 words", 64'(popq.size()), 64'd4);
        chk("s4 word1", 64'(popq[0]), {31'd0, 1'b0, 32'h20031003});
        chk("s4 word2", 64'(popq[1]), {31'd0, 1'b1, 32'h20041004});
        chk("s4 word3", 64'(popq[2]), {31'd0, 1'b0, 32'h20051005});
        chk("s4 word4", 64'(popq[3]), {31'd0, 1'b1, 32'h20061006});
        chk("s4 busy",     64'(bus.busy),     64'd0);
        chk("s4 overflow", 64'(bus.overflow), 64'd1);

        // Reset while capturing, with three words queued and overflow set
        start_scen();
        cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b1);
        chk("s6 pre valid",    64'(bus.dout_valid), 64'd1);
        chk("s6 pre dout",     64'(bus.dout),       64'h20041004);
        chk("s6 pre overflow", 64'(bus.overflow),   64'd1);
        bus.rd_issue   = 1'b0;
        bus.dout_ready = 1'b0;
        sys_rst_n      = 1'b0;
        #1;
        chk("s6 rst valid",    64'(bus.dout_valid), 64'd0);
        chk("s6 rst busy",     64'(bus.busy),       64'd0);
        chk("s6 rst overflow", 64'(bus.overflow),   64'd0);
        chk("s6 rst dout",     64'(bus.dout),       64'd0);
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        scen1("s6");

        // rd_lat=0 behaves as latency 1
        bus.rd_lat = 4'd0;
        start_scen();
        cyc(1'b1, 1'b1); cyc(1'b0, 1'b1);
        chk("l0 c1 valid", 64'(bus.dout_valid), 64'd0);
        cyc(1'b0, 1'b1);
        chk("l0 c2 dout", {31'd0, bus.dout_last, bus.dout}, {31'd0, 1'b0, 32'h20011001});
        cyc(1'b0, 1'b1);
        chk("l0 c3 dout", {31'd0, bus.dout_last, bus.dout}, {31'd0, 1'b1, 32'h20021002});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
